// File: rtl/tdm_demux2_if.sv
// Serial TDM link bundle: bit stream in, two parallel channel words out.
// The bench drives through master; the demux sits on slave.
interface tdm_demux2_if #(
  parameter int WIDTH = 8
);
  logic             din;
  logic             din_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] x_data;
  logic             x_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_valid;
  logic             slot;
  logic             locked;
  logic             sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  x_data, x_valid, y_data, y_valid,
    input  slot, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output x_data, x_valid, y_data, y_valid,
    output slot, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux2.sv
// Two-slot TDM demultiplexer: serial MSB-first x/y slots to words.
// Slot 0 -> x, slot 1 -> y, matching the transmit-side mux.
module tdm_demux2 #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  tdm_demux2_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SLOT_X = 2'd1,
    SLOT_Y = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] xd_q, xd_d;
  logic [WIDTH-1:0] yd_q, yd_d;
  logic             xv_q, xv_d;
  logic             yv_q, yv_d;
  logic             se_q, se_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first;

  assign shifted = {sh_q[WIDTH-2:0], bus.din};
  assign first   = {{(WIDTH-1){1'b0}}, bus.din};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      sh_q    <= '0;
      xd_q    <= '0;
      yd_q    <= '0;
      xv_q    <= 1'b0;
      yv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      xd_q    <= xd_d;
      yd_q    <= yd_d;
      xv_q    <= xv_d;
      yv_q    <= yv_d;
      se_q    <= se_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    xd_d    = xd_q;
    yd_d    = yd_q;
    xv_d    = 1'b0;
    yv_d    = 1'b0;
    se_d    = 1'b0;
    if (bus.din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (bus.frame_sync) begin
            sh_d    = first;
            cnt_d   = CW'(1);
            state_d = SLOT_X;
          end
        end
        SLOT_X: begin
          // A sync on a word boundary is a normal frame start.
          if (bus.frame_sync && cnt_q != '0) begin
            se_d  = 1'b1;
            sh_d  = first;
            cnt_d = CW'(1);
          end else if (cnt_q == LAST) begin
            sh_d    = shifted;
            xd_d    = shifted;
            xv_d    = 1'b1;
            cnt_d   = '0;
            state_d = SLOT_Y;
          end else begin
            sh_d  = shifted;
            cnt_d = cnt_q + CW'(1);
          end
        end
        SLOT_Y: begin
          if (bus.frame_sync) begin
            se_d    = 1'b1;
            sh_d    = first;
            cnt_d   = CW'(1);
            state_d = SLOT_X;
          end else if (cnt_q == LAST) begin
            sh_d    = shifted;
            yd_d    = shifted;
            yv_d    = 1'b1;
            cnt_d   = '0;
            state_d = SLOT_X;
          end else begin
            sh_d  = shifted;
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = HUNT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus.x_data   = xd_q;
  assign bus.y_data   = yd_q;
  assign bus.x_valid  = xv_q;
  assign bus.y_valid  = yv_q;
  assign bus.sync_err = se_q;
  assign bus.slot     = (state_q == SLOT_Y);
  assign bus.locked   = (state_q == SLOT_X) || (state_q == SLOT_Y);

endmodule
